// File: rtl/divu_pkg.sv
// Shared definitions for the sequential unsigned restoring divider.
package divu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/divu_seq_if.sv
// Operand/result bundle between a requester and the sequential divider.
interface divu_seq_if
   import divu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             Run;
   logic [WIDTH-1:0] Dividend;
   logic [WIDTH-1:0] Divisor;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic             Ready;
   logic             DivZero;

   modport master (
      output Run, Dividend, Divisor,
      input  Quotient, Remainder, Ready, DivZero
   );

   modport slave (
      input  Run, Dividend, Divisor,
      output Quotient, Remainder, Ready, DivZero
   );

endinterface

// File: rtl/divu_trial_sub.sv
// Trial subtraction of the divisor from the shifted partial remainder.
module divu_trial_sub
   import divu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   R_shifted,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH:0]   diff,
   output logic             ge
);

   // One extra bit on top acts as the borrow out of the subtraction.
   logic [WIDTH+1:0] sub;

   assign sub  = {1'b0, R_shifted} - {2'b00, D};
   assign diff = sub[WIDTH:0];
   assign ge   = ~sub[WIDTH+1];

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
module divu_seq
   import divu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic       clk,
   input  logic       Reset,
   divu_seq_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] r_q, r_nx;
   logic [WIDTH-1:0] q_q, q_nx;
   logic [WIDTH-1:0] d_q, d_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;
   logic [WIDTH-1:0] quo_q, quo_nx;
   logic [WIDTH-1:0] rem_q, rem_nx;
   logic             rdy_q, rdy_nx;
   logic             dz_q, dz_nx;

   logic [WIDTH:0]   r_shifted;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic             unused_diff_msb;

   assign r_shifted = {r_q, q_q[WIDTH-1]};

   divu_trial_sub #(.WIDTH(WIDTH)) u_trial (
      .R_shifted (r_shifted),
      .D         (d_q),
      .diff      (diff),
      .ge        (ge)
   );

   // A successful trial always leaves a remainder below D, so the top bit is zero.
   assign unused_diff_msb = diff[WIDTH];

   always_comb begin
      state_nx = state;
      r_nx     = r_q;
      q_nx     = q_q;
      d_nx     = d_q;
      cnt_nx   = cnt_q;
      quo_nx   = quo_q;
      rem_nx   = rem_q;
      rdy_nx   = rdy_q;
      dz_nx    = dz_q;
      case (state)
         IDLE: begin
            if (bus.Run) begin
               r_nx   = '0;
               q_nx   = bus.Dividend;
               d_nx   = bus.Divisor;
               cnt_nx = '0;
               rdy_nx = 1'b0;
               dz_nx  = 1'b0;
               if (bus.Divisor == '0) begin
                  state_nx = DONE;
                  quo_nx   = '1;
                  rem_nx   = bus.Dividend;
                  rdy_nx   = 1'b1;
                  dz_nx    = 1'b1;
               end else begin
                  state_nx = ITER;
               end
            end
         end
         ITER: begin
            r_nx   = ge ? diff[WIDTH-1:0] : r_shifted[WIDTH-1:0];
            q_nx   = {q_q[WIDTH-2:0], ge};
            cnt_nx = cnt_q + CW'(1);
            // The final step publishes its own freshly computed Q and R.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_nx = DONE;
               quo_nx   = q_nx;
               rem_nx   = r_nx;
               rdy_nx   = 1'b1;
            end
         end
         DONE: begin
            if (!bus.Run) begin
               state_nx = IDLE;
               rdy_nx   = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state <= IDLE;
         r_q   <= '0;
         q_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         rdy_q <= 1'b0;
         dz_q  <= 1'b0;
      end else begin
         state <= state_nx;
         r_q   <= r_nx;
         q_q   <= q_nx;
         d_q   <= d_nx;
         cnt_q <= cnt_nx;
         quo_q <= quo_nx;
         rem_q <= rem_nx;
         rdy_q <= rdy_nx;
         dz_q  <= dz_nx;
      end
   end

   assign bus.Quotient  = quo_q;
   assign bus.Remainder = rem_q;
   assign bus.Ready     = rdy_q;
   assign bus.DivZero   = dz_q;

endmodule

// File: doc/divu_seq.md
DIVU_SEQ -- requirements
Module: divu_seq

Interface
REQ-001 Parameter WIDTH, default 32, is the operand, quotient and remainder width in bits.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Run  input  1  is the start request; it is sampled only in IDLE and in DONE.
REQ-005 Dividend  input  WIDTH  is the unsigned dividend, captured in the load cycle.
REQ-006 Divisor  input  WIDTH  is the unsigned divisor, captured in the load cycle.
REQ-007 Quotient  output  WIDTH  is the unsigned quotient, registered.
REQ-008 Remainder  output  WIDTH  is the unsigned remainder, registered.
REQ-009 Ready  output  1  signals that the result is valid, registered.
REQ-010 DivZero  output  1  flags a zero divisor for the current result, registered.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, ITER and DONE.
REQ-012 IDLE with Run=1 SHALL load the operands and set Ready=0 and DivZero=0:
- R=0, Q=Dividend, D=Divisor, counter=0;
- go to ITER, or to DONE if Divisor==0.
REQ-013 IDLE with Run=0 SHALL hold all registers and outputs.
REQ-014 Each ITER cycle SHALL perform one restoring step:
- shift {R,Q} left by 1;
- form the (WIDTH+1)-bit difference R_shifted - D;
- if it is non-negative, set R=difference and Q[0]=1; otherwise keep R_shifted and set Q[0]=0.
REQ-015 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and increment once per ITER cycle.
REQ-016 ITER SHALL go to DONE in the cycle that performs step WIDTH (counter==WIDTH-1).
REQ-017 Run SHALL be ignored during ITER; deasserting it does not abort the operation.
REQ-018 Latency SHALL be WIDTH+1 edges from the load edge until Ready reads 1 (33 edges for WIDTH=32).
REQ-019 On entry to DONE, the block SHALL drive Quotient=Q, Remainder=R, Ready=1.
REQ-020 Divide by zero SHALL go directly to DONE with Quotient=all ones, Remainder=Dividend, DivZero=1, Ready=1 one edge after the load.
REQ-021 DONE SHALL hold all outputs while Run=1; a new operation requires Run to drop first.
REQ-022 DONE with Run=0 SHALL go to IDLE, clearing Ready while Quotient, Remainder and DivZero keep their values.
REQ-023 Quotient and Remainder SHALL change only on entry to DONE or on Reset, never during ITER.

Reset
REQ-024 Reset SHALL have priority over every other condition, including mid-ITER.
REQ-025 Reset SHALL force state=IDLE, counter=0, R=Q=D=0, Quotient=0, Remainder=0, Ready=0, DivZero=0 on the next edge.
REQ-026 After Reset is released, the block SHALL accept Run in the first cycle.

Structure
REQ-027 A shared package divu_pkg SHALL hold:
- the state enumeration (IDLE, ITER, DONE);
- the default WIDTH;
- the counter-width constant.
REQ-028 The (WIDTH+1)-bit trial subtract-and-compare SHALL be a sub-module named divu_trial_sub, with inputs R_shifted and D and outputs diff and ge.
REQ-029 The rest of the block SHALL be a single FSM plus the datapath registers; there SHALL be no other sub-modules.

Verification
REQ-030 Dividend=100, Divisor=7, Run pulse -> Ready=1 exactly 33 edges after load, Quotient=14, Remainder=2, DivZero=0.
REQ-031 Dividend=0xFFFFFFFF, Divisor=1 -> Quotient=0xFFFFFFFF, Remainder=0. Dividend=3, Divisor=10 -> Quotient=0, Remainder=3.
REQ-032 Dividend=5, Divisor=0 -> Ready=1 one edge after load, Quotient=0xFFFFFFFF, Remainder=5, DivZero=1.
REQ-033 Reset asserted at iteration 10 of 100/7 -> next edge: state IDLE, all outputs 0; a following 9/4 run gives Quotient=2, Remainder=1.
REQ-034 Run held high through DONE for 5 cycles -> outputs stable, no restart; Run low for 1 cycle, then high with 50/5 -> Quotient=10, Remainder=0.
REQ-035 Run toggled during ITER -> result unchanged versus the reference run; randomized operands checked against the software quotient and remainder.
